aes_core_arb: RTL and testbench

AES_CORE_ARB -- requirements
Module: aes_core_arb

---
 rtl/aes_core_arb.sv | 170 +++++++++++++++++
 tb/tb_aes_core_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arb.sv
// Round-robin front end that shares one AES cipher core between two requesters.
// One block is in flight at a time; the core is watched with a timeout and the result is held until taken.
module aes_core_arb #(
    parameter int TMO_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_text,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_text,
    input  logic [127:0] req1_key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_text,
    output logic         rsp_id,
    output logic         rsp_err,
    output logic         core_ld,
    output logic [127:0] core_key,
    output logic [127:0] core_text_in,
    input  logic         core_done,
    input  logic [127:0] core_text_out,
    output logic [15:0]  ops_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [7:0] TMO_C = 8'(TMO_CYCLES);

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           id_q, id_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   text_q, text_d;
    logic [127:0]   rsp_text_q, rsp_text_d;
    logic           core_ld_q, core_ld_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_err_q, rsp_err_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [15:0]    ops_cnt_q, ops_cnt_d;
    logic           grant_s;
    logic           grant_id_s;

    // Round-robin pick: alternate on contention, otherwise serve whoever is waiting
    always_comb begin
        grant_s    = 1'b0;
        grant_id_s = 1'b0;
        if (rst && (state_q == IDLE) && (req0_valid || req1_valid)) begin
            grant_s = 1'b1;
            if (req0_valid && req1_valid) begin
                grant_id_s = ~last_grant_q;
            end else begin
                grant_id_s = req1_valid;
            end
        end else begin
            grant_s = 1'b0;
        end
    end

    assign req0_ready = grant_s & ~grant_id_s & req0_valid;
    assign req1_ready = grant_s & grant_id_s & req1_valid;

    // Next-state and datapath updates for the arbiter FSM
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        key_d        = key_q;
        text_d       = text_q;
        core_ld_d    = 1'b0;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_text_d   = rsp_text_q;
        rsp_err_d    = rsp_err_q;
        ops_cnt_d    = ops_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d      = LOAD;
                    last_grant_d = grant_id_s;
                    id_d         = grant_id_s;
                    key_d        = grant_id_s ? req1_key : req0_key;
                    text_d       = grant_id_s ? req1_text : req0_text;
                    core_ld_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = BUSY;
                cnt_d   = 8'd0;
            end
            BUSY: begin
                // A done arriving on the timeout cycle still wins
                if (core_done) begin
                    rsp_text_d  = core_text_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if ((cnt_q + 8'd1) == TMO_C) begin
                    cnt_d       = cnt_q + 8'd1;
                    rsp_text_d  = 128'd0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_cnt_d   = ops_cnt_q + 16'd1;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            key_q        <= 128'd0;
            text_q       <= 128'd0;
            rsp_text_q   <= 128'd0;
            core_ld_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            cnt_q        <= 8'd0;
            ops_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            key_q        <= key_d;
            text_q       <= text_d;
            rsp_text_q   <= rsp_text_d;
            core_ld_q    <= core_ld_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
            ops_cnt_q    <= ops_cnt_d;
        end
    end

    assign core_ld      = core_ld_q;
    assign core_key     = key_q;
    assign core_text_in = text_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_text     = rsp_text_q;
    assign rsp_id       = id_q;
    assign rsp_err      = rsp_err_q;
    assign ops_cnt      = ops_cnt_q;

endmodule

// File: tb/tb_aes_core_arb.sv
// Bench for aes_core_arb: emulated cipher core, transaction-timeline model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_aes_core_arb;
    localparam int TMO   = 64;
    localparam int NEVER = 1000;
    localparam logic [127:0] REF_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] REF_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] REF_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_text = 128'd0, req0_key = 128'd0, req1_text = 128'd0, req1_key = 128'd0;
    logic         rsp_valid, rsp_id, rsp_err;
    logic         rsp_ready = 1'b1;
    logic [127:0] rsp_text;
    logic         core_ld;
    logic [127:0] core_key, core_text_in;
    logic         core_done = 1'b0;
    logic [127:0] core_text_out = 128'd0;
    logic [15:0]  ops_cnt;

    aes_core_arb #(.TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_text(req0_text), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_text(req1_text), .req1_key(req1_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
        .core_done(core_done), .core_text_out(core_text_out), .ops_cnt(ops_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int core_lat = 10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act_v, input logic [127:0] exp_v);
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act_v, exp_v);
        end
    endtask

    // Stand-in cipher: the real AES answer for the reference vector, a cheap mix otherwise
    function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k);
        if (t == REF_PT && k == REF_KEY) return REF_CT;
        else return t ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Core emulator: answers core_lat cycles after a load, and keeps going regardless of reset
    int done_cyc = -1;
    logic [127:0] done_val = 128'd0;
    always @(negedge clk) begin
        if (core_ld === 1'b1) begin
            done_cyc = (core_lat >= NEVER) ? -1 : cyc + core_lat;
            done_val = core_fn(core_text_in, core_key);
        end
    end
    always @(posedge clk) begin
        #1;
        core_done     = (cyc == done_cyc);
        core_text_out = core_done ? done_val : 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    end

    // Transaction model: one block in flight, response appears grant + 2 + min(latency, TMO)
    logic         m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, m_err = 1'b0;
    logic [127:0] m_key = 128'd0, m_text = 128'd0, m_rtext = 128'd0;
    logic [15:0]  m_ops = 16'd0;
    int           m_g = 0, m_resp = 0, lat_eff = 0;
    logic         e_gnt, e_gid, e_ld, e_v;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 1'b0; m_last = 1'b1; m_id = 1'b0; m_err = 1'b0;
            m_key = 128'd0; m_text = 128'd0; m_rtext = 128'd0; m_ops = 16'd0;
            chk("rst_req0_ready", req0_ready, 1'b0);
            chk("rst_req1_ready", req1_ready, 1'b0);
            chk("rst_core_ld", core_ld, 1'b0);
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_rsp_err", rsp_err, 1'b0);
            chk("rst_rsp_id", rsp_id, 1'b0);
            chk("rst_rsp_text", rsp_text, 128'd0);
            chk("rst_core_key", core_key, 128'd0);
            chk("rst_core_text_in", core_text_in, 128'd0);
            chk("rst_ops_cnt", ops_cnt, 16'd0);
        end else begin
            e_gnt = 1'b0;
            e_gid = 1'b0;
            if (!m_busy && (req0_valid || req1_valid)) begin
                e_gnt = 1'b1;
                e_gid = (req0_valid && req1_valid) ? !m_last : req1_valid;
            end
            e_ld = m_busy && (cyc == m_g + 1);
            e_v  = m_busy && (cyc >= m_resp);
            chk("req0_ready", req0_ready, e_gnt && !e_gid);
            chk("req1_ready", req1_ready, e_gnt && e_gid);
            chk("core_ld", core_ld, e_ld);
            chk("rsp_valid", rsp_valid, e_v);
            chk("core_key", core_key, m_key);
            chk("core_text_in", core_text_in, m_text);
            chk("ops_cnt", ops_cnt, m_ops);
            if (e_v) begin
                chk("rsp_text", rsp_text, m_rtext);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_err", rsp_err, m_err);
            end
            if (e_v && rsp_ready) begin
                m_busy = 1'b0;
                m_ops++;
            end
            if (e_gnt) begin
                m_busy  = 1'b1;
                m_g     = cyc;
                m_id    = e_gid;
                m_last  = e_gid;
                m_text  = e_gid ? req1_text : req0_text;
                m_key   = e_gid ? req1_key : req0_key;
                m_err   = (core_lat > TMO);
                lat_eff = m_err ? TMO : core_lat;
                m_resp  = cyc + 2 + lat_eff;
                m_rtext = m_err ? 128'd0 : core_fn(m_text, m_key);
            end
        end
    end

    task automatic send(input logic id, input logic [127:0] t, input logic [127:0] k, output int g);
        g = -1;
        if (id) begin req1_valid = 1'b1; req1_text = t; req1_key = k; end
        else    begin req0_valid = 1'b1; req0_text = t; req0_key = k; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                g = cyc;
                break;
            end
        end
        chk("grant_seen", g >= 0, 1'b1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cyc, output int r);
        r = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                r = cyc;
                break;
            end
        end
        chk("rsp_seen", r >= 0, 1'b1);
    endtask

    int g, r, h, gb, ng, nr;
    logic gq [8];
    logic rq [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;

        // Reference vector, 10-cycle core
        core_lat = 10;
        send(1'b0, REF_PT, REF_KEY, g);
        wait_rsp(40, r);
        chk("t1_latency", r - g, 12);
        chk("t1_rsp_text", rsp_text, REF_CT);
        chk("t1_rsp_id", rsp_id, 1'b0);
        chk("t1_rsp_err", rsp_err, 1'b0);
        @(negedge clk);
        chk("t1_ops_cnt", ops_cnt, 16'd1);

        // Single req1 so the contention run starts with req0
        core_lat = 5;
        @(posedge clk); #1;
        send(1'b1, 128'h0123456789abcdef0123456789abcdef, 128'h1, g);
        wait_rsp(20, r);
        chk("t2_rsp_id", rsp_id, 1'b1);

        // Contention: both held valid for four blocks
        core_lat = 3;
        @(posedge clk); #1;
        req0_text = 128'h11111111111111111111111111111111; req0_key = 128'hab;
        req1_text = 128'h22222222222222222222222222222222; req1_key = 128'hcd;
        req0_valid = 1'b1; req1_valid = 1'b1;
        ng = 0; nr = 0;
        for (int i = 0; i < 300 && nr < 4; i++) begin
            @(negedge clk);
            if (req0_ready === 1'b1 && ng < 8) begin gq[ng] = 1'b0; ng++; end
            if (req1_ready === 1'b1 && ng < 8) begin gq[ng] = 1'b1; ng++; end
            if (rsp_valid === 1'b1 && rsp_ready && nr < 8) begin rq[nr] = rsp_id; nr++; end
            @(posedge clk); #1;
            if (ng >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        chk("cont_resp_count", nr, 4);
        for (int i = 0; i < 4; i++) begin
            chk("cont_grant_order", gq[i], (i % 2) == 1);
            chk("cont_rsp_id_order", rq[i], (i % 2) == 1);
        end

        // Backpressure: hold the response for 20 cycles with req1 waiting
        core_lat = 4;
        rsp_ready = 1'b0;
        send(1'b0, 128'h00000000ffffffff00000000ffffffff, 128'h77, g);
        req1_valid = 1'b1; req1_text = 128'h5; req1_key = 128'h6;
        wait_rsp(20, r);
        repeat (20) @(negedge clk);
        chk("bp_still_valid", rsp_valid, 1'b1);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        h = cyc;
        gb = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req1_ready === 1'b1) begin gb = cyc; break; end
        end
        chk("bp_next_grant_gap", gb - h, 1);
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_rsp(20, r);

        // Timeout, done exactly on the last busy cycle, and done one cycle too late
        core_lat = NEVER;
        @(posedge clk); #1;
        send(1'b1, 128'hcafe, 128'hbeef, g);
        wait_rsp(100, r);
        chk("tmo_latency", r - g, 66);
        chk("tmo_rsp_err", rsp_err, 1'b1);
        chk("tmo_rsp_text", rsp_text, 128'd0);
        core_lat = 64;
        @(posedge clk); #1;
        send(1'b0, 128'hface, 128'hfeed, g);
        wait_rsp(100, r);
        chk("edge_latency", r - g, 66);
        chk("edge_rsp_err", rsp_err, 1'b0);
        chk("edge_rsp_text", rsp_text, core_fn(128'hface, 128'hfeed));
        core_lat = 65;
        @(posedge clk); #1;
        send(1'b0, 128'h1234, 128'h5678, g);
        wait_rsp(100, r);
        chk("late_rsp_err", rsp_err, 1'b1);

        // Reset in the middle of BUSY
        core_lat = 20;
        @(posedge clk); #1;
        send(1'b1, 128'h9999, 128'h8888, g);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_core_ld", core_ld, 1'b0);
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        chk("arst_core_key", core_key, 128'd0);
        chk("arst_core_text_in", core_text_in, 128'd0);
        chk("arst_ops_cnt", ops_cnt, 16'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_req0_granted", req0_ready, 1'b1);
        chk("post_rst_req1_idle", req1_ready, 1'b0);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(40, r);
        chk("post_rst_rsp_id", rsp_id, 1'b0);

        // Wrap: park the counter just below the top while idle, then finish two blocks
        core_lat = 1;
        @(posedge clk); #2;
        force dut.ops_cnt_q = 16'hfffe;
        m_ops = 16'hfffe;
        @(posedge clk); #2;
        release dut.ops_cnt_q;
        @(posedge clk); #1;
        send(1'b0, 128'h42, 128'h43, g);
        wait_rsp(10, r);
        @(posedge clk); #1;
        send(1'b1, 128'h44, 128'h45, g);
        wait_rsp(10, r);
        @(negedge clk);
        chk("wrap_ops_cnt", ops_cnt, 16'h0000);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
